// File: rtl/mac_seq_ctrl_if.sv
// Handshake and control bundle between a dot-product job issuer and the
// MAC sequencing controller. The master drives the job and operand-feed
// controls; the slave (the controller) drives the accumulator strobes and
// the result status.
interface mac_seq_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_len;
  logic             in_valid;
  logic             in_ready;
  logic             acc_clean;
  logic             acc_en;
  logic             acc_vbit;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  modport master (
    output start, abort, cfg_len, in_valid, res_ready,
    input  in_ready, acc_clean, acc_en, acc_vbit, res_valid, busy
  );

  modport slave (
    input  start, abort, cfg_len, in_valid, res_ready,
    output in_ready, acc_clean, acc_en, acc_vbit, res_valid, busy
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC sequencing controller: runs one dot-product job of len_q elements.
// It clears the accumulator, accepts operand pairs, delays each accepted
// element by PIPE_LAT cycles to line up with the multiplier output, flags
// the final element, and then holds the result until the consumer takes it.
module mac_seq_ctrl #(
  parameter int CNT_W    = 5,
  parameter int PIPE_LAT = 2
) (
  input logic          clk,
  input logic          rst,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_len;
  logic [3:0]          r_drain;
  logic [PIPE_LAT-1:0] r_en_pipe;
  logic [PIPE_LAT-1:0] r_last_pipe;
  logic                r_in_ready;
  logic                r_acc_clean;
  logic                r_res_valid;
  logic                r_busy;

  logic                w_hs;
  logic                w_last;
  logic [PIPE_LAT-1:0] w_en_shift;
  logic [PIPE_LAT-1:0] w_last_shift;

  // An element is accepted only while in_ready is registered high.
  assign w_hs   = bus.in_valid & r_in_ready;
  // Compare one bit wider so cnt+1 can never wrap against a full-scale len_q.
  assign w_last = (({1'b0, r_cnt} + (CNT_W+1)'(1)) == {1'b0, r_len});

  // Next contents of the enable and last-flag delay lines.
  if (PIPE_LAT == 1) begin : g_pipe_one
    assign w_en_shift   = w_hs;
    assign w_last_shift = w_hs & w_last;
  end else begin : g_pipe_many
    assign w_en_shift   = {r_en_pipe[PIPE_LAT-2:0], w_hs};
    assign w_last_shift = {r_last_pipe[PIPE_LAT-2:0], w_hs & w_last};
  end

  // Job FSM, element counter, delay lines and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_drain     <= 4'd0;
      r_en_pipe   <= '0;
      r_last_pipe <= '0;
      r_in_ready  <= 1'b0;
      r_acc_clean <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.abort) begin
      // Abort beats start and flushes any element still in flight.
      r_state     <= S_IDLE;
      r_en_pipe   <= '0;
      r_last_pipe <= '0;
      r_in_ready  <= 1'b0;
      r_acc_clean <= 1'b1;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_acc_clean <= 1'b0;
      r_en_pipe   <= w_en_shift;
      r_last_pipe <= w_last_shift;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_len       <= bus.cfg_len;
            r_cnt       <= '0;
            r_acc_clean <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_CLEAR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (r_len == '0) begin
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_ACC;
          end
        end
        S_ACC: begin
          if (w_hs) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_in_ready <= 1'b0;
              r_drain    <= 4'd0;
              r_state    <= S_DRAIN;
            end else begin
              r_state <= S_ACC;
            end
          end else begin
            r_state <= S_ACC;
          end
        end
        S_DRAIN: begin
          // The final element's acc_en lands in the last drain cycle.
          if (r_drain == 4'(PIPE_LAT - 1)) begin
            r_res_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_drain <= r_drain + 4'd1;
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_in_ready  <= 1'b0;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.acc_clean = r_acc_clean;
  assign bus.acc_en    = r_en_pipe[PIPE_LAT-1];
  assign bus.acc_vbit  = r_last_pipe[PIPE_LAT-1];
  assign bus.res_valid = r_res_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl (CNT_W=5, PIPE_LAT=2). Each directed job
// pushes its hand-computed event cycles into queues; a negedge monitor pops
// and compares whenever the DUT raises acc_clean, acc_en or toggles res_valid.
module tb_mac_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_hs = 0;
  logic prev_rv = 1'b0;

  typedef struct {
    int   cyc;
    logic vbit;
  } en_t;

  en_t en_q[$];
  int  clean_q[$];
  int  rise_q[$];
  int  fall_q[$];

  mac_seq_ctrl_if #(.CNT_W(5)) bus_if ();

  mac_seq_ctrl #(.CNT_W(5), .PIPE_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) next_cyc();
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, int'({bus_if.in_ready, bus_if.acc_clean, bus_if.acc_en,
                    bus_if.acc_vbit, bus_if.res_valid, bus_if.busy}), 0);
  endtask

  // Monitor: pop the expected event whenever the DUT presents one.
  always @(negedge clk) begin
    en_t e;
    int  c;
    if (bus_if.in_valid === 1'b1 && bus_if.in_ready === 1'b1) n_hs++;
    if (bus_if.acc_clean === 1'b1) begin
      if (clean_q.size() == 0) chk("acc_clean_unexpected", cyc, -1);
      else begin
        c = clean_q.pop_front();
        chk("acc_clean_cycle", cyc, c);
      end
    end
    if (bus_if.acc_en === 1'b1) begin
      if (en_q.size() == 0) chk("acc_en_unexpected", cyc, -1);
      else begin
        e = en_q.pop_front();
        chk("acc_en_cycle", cyc, e.cyc);
        chk("acc_vbit", int'(bus_if.acc_vbit), int'(e.vbit));
      end
    end
    if (bus_if.acc_vbit === 1'b1 && bus_if.acc_en !== 1'b1)
      chk("acc_vbit_without_en", 1, 0);
    if (bus_if.res_valid === 1'b1 && !prev_rv) begin
      if (rise_q.size() == 0) chk("res_valid_rise_unexpected", cyc, -1);
      else begin
        c = rise_q.pop_front();
        chk("res_valid_rise_cycle", cyc, c);
      end
    end
    if (bus_if.res_valid !== 1'b1 && prev_rv) begin
      if (fall_q.size() == 0) chk("res_valid_fall_unexpected", cyc, -1);
      else begin
        c = fall_q.pop_front();
        chk("res_valid_fall_cycle", cyc, c);
      end
    end
    prev_rv <= (bus_if.res_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int hs0;

    rst              = 1'b1;
    bus_if.start     = 1'b0;
    bus_if.abort     = 1'b0;
    bus_if.cfg_len   = 5'd0;
    bus_if.in_valid  = 1'b0;
    bus_if.res_ready = 1'b1;

    // Reset state
    repeat (3) next_cyc();
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    repeat (2) next_cyc();

    // Basic job, len 4, in_valid held high; cfg_len change after capture ignored
    s = cyc; hs0 = n_hs;
    bus_if.start = 1'b1; bus_if.cfg_len = 5'd4; bus_if.in_valid = 1'b1;
    clean_q.push_back(s + 1);
    en_q.push_back('{s + 4, 1'b0});
    en_q.push_back('{s + 5, 1'b0});
    en_q.push_back('{s + 6, 1'b0});
    en_q.push_back('{s + 7, 1'b1});
    rise_q.push_back(s + 8);
    fall_q.push_back(s + 9);
    next_cyc();
    bus_if.start = 1'b0; bus_if.cfg_len = 5'd7;
    chk("basic_busy_clear", int'(bus_if.busy), 1);
    wait_until(s + 8);
    chk("basic_busy_done", int'(bus_if.busy), 1);
    wait_until(s + 9);
    chk("basic_busy_idle", int'(bus_if.busy), 0);
    chk("basic_handshakes", n_hs - hs0, 4);
    bus_if.in_valid = 1'b0;
    repeat (2) next_cyc();

    // Abort together with start in IDLE: only a clean pulse
    s = cyc;
    bus_if.start = 1'b1; bus_if.abort = 1'b1; bus_if.cfg_len = 5'd3;
    clean_q.push_back(s + 1);
    next_cyc();
    bus_if.start = 1'b0; bus_if.abort = 1'b0;
    chk("idle_abort_busy", int'(bus_if.busy), 0);
    wait_until(s + 3);
    chk("idle_abort_still_idle", int'(bus_if.busy), 0);
    next_cyc();

    // Zero-length job
    s = cyc;
    bus_if.start = 1'b1; bus_if.cfg_len = 5'd0;
    clean_q.push_back(s + 1);
    rise_q.push_back(s + 2);
    fall_q.push_back(s + 3);
    next_cyc();
    bus_if.start = 1'b0;
    wait_until(s + 5);

    // Bubbles: len 3, in_valid 1,0,1,1 from s+2
    s = cyc; hs0 = n_hs;
    bus_if.start = 1'b1; bus_if.cfg_len = 5'd3;
    clean_q.push_back(s + 1);
    en_q.push_back('{s + 4, 1'b0});
    en_q.push_back('{s + 6, 1'b0});
    en_q.push_back('{s + 7, 1'b1});
    rise_q.push_back(s + 8);
    fall_q.push_back(s + 9);
    next_cyc();
    bus_if.start = 1'b0;
    wait_until(s + 2); bus_if.in_valid = 1'b1;
    wait_until(s + 3); bus_if.in_valid = 1'b0;
    wait_until(s + 4); bus_if.in_valid = 1'b1;
    wait_until(s + 6); bus_if.in_valid = 1'b0;
    wait_until(s + 10);
    chk("bubble_handshakes", n_hs - hs0, 3);
    next_cyc();

    // Result back-pressure, start while in DONE ignored
    s = cyc;
    bus_if.start = 1'b1; bus_if.cfg_len = 5'd1; bus_if.in_valid = 1'b1;
    bus_if.res_ready = 1'b0;
    clean_q.push_back(s + 1);
    en_q.push_back('{s + 4, 1'b1});
    rise_q.push_back(s + 5);
    fall_q.push_back(s + 11);
    next_cyc();
    bus_if.start = 1'b0;
    wait_until(s + 3); bus_if.in_valid = 1'b0;
    for (int c = s + 5; c <= s + 9; c++) begin
      wait_until(c);
      chk("bp_res_valid_held", int'(bus_if.res_valid), 1);
      chk("bp_busy_held", int'(bus_if.busy), 1);
      bus_if.start   = (c == s + 7);
      bus_if.cfg_len = 5'd2;
    end
    wait_until(s + 10);
    bus_if.res_ready = 1'b1;
    wait_until(s + 11);
    chk("bp_res_valid_dropped", int'(bus_if.res_valid), 0);
    chk("bp_busy_idle", int'(bus_if.busy), 0);
    repeat (3) next_cyc();

    // Abort mid-ACC after 2 of 6 elements
    s = cyc; hs0 = n_hs;
    bus_if.start = 1'b1; bus_if.cfg_len = 5'd6; bus_if.in_valid = 1'b1;
    clean_q.push_back(s + 1);
    en_q.push_back('{s + 4, 1'b0});
    clean_q.push_back(s + 5);
    next_cyc();
    bus_if.start = 1'b0;
    wait_until(s + 4);
    bus_if.in_valid = 1'b0; bus_if.abort = 1'b1;
    wait_until(s + 5);
    bus_if.abort = 1'b0;
    chk("abort_busy", int'(bus_if.busy), 0);
    chk("abort_in_ready", int'(bus_if.in_ready), 0);
    wait_until(s + 12);
    chk("abort_handshakes", n_hs - hs0, 2);

    // Max length 31, reset in the final DRAIN cycle
    s = cyc; hs0 = n_hs;
    bus_if.start = 1'b1; bus_if.cfg_len = 5'd31; bus_if.in_valid = 1'b1;
    clean_q.push_back(s + 1);
    for (int k = 4; k <= 34; k++) en_q.push_back('{s + k, (k == 34)});
    next_cyc();
    bus_if.start = 1'b0;
    wait_until(s + 33);
    chk("max_in_ready_stopped", int'(bus_if.in_ready), 0);
    wait_until(s + 34);
    rst = 1'b1;
    wait_until(s + 35);
    chk_all_zero("max_rst_mid_drain");
    rst = 1'b0; bus_if.in_valid = 1'b0;
    chk("max_handshakes", n_hs - hs0, 31);
    repeat (5) next_cyc();

    // Every expected event must have been seen
    chk("left_acc_en", en_q.size(), 0);
    chk("left_acc_clean", clean_q.size(), 0);
    chk("left_res_valid_rise", rise_q.size(), 0);
    chk("left_res_valid_fall", fall_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 5: width of the element counter and of cfg_len.
REQ-002 SHALL have parameter PIPE_LAT, default 2, legal range 1..8: cycles from element acceptance to accumulator-register enable.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin a dot-product job; sampled only in IDLE.
REQ-006 abort  in  1  cancel the current job from any state.
REQ-007 cfg_len  in  CNT_W  element count for the job; captured when start is accepted.
REQ-008 in_valid  in  1  operand pair valid from the upstream multiplier feed.
REQ-009 in_ready  out  1  controller accepts an operand pair this cycle.
REQ-010 acc_clean  out  1  clear strobe to the accumulator register.
REQ-011 acc_en  out  1  load enable to the accumulator register.
REQ-012 acc_vbit  out  1  valid-bit input to the accumulator register; marks the final sum.
REQ-013 res_valid  out  1  result in the accumulator register is complete.
REQ-014 res_ready  in  1  consumer has taken the result.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, ACC, DRAIN and DONE, with every output registered.
REQ-017 IDLE: start=1 -> capture cfg_len into len_q and go to CLEAR.
REQ-018 CLEAR: lasts exactly 1 cycle with acc_clean=1 and in_ready=0; go to DONE if len_q==0, else to ACC.
REQ-019 ACC: in_ready=1; each cycle with in_valid&in_ready increments cnt, which is reset to 0 on entry to CLEAR.
REQ-020 ACC: the handshake on element len_q (cnt==len_q-1) moves the FSM to DRAIN, and in_ready=0 from the next cycle.
REQ-021 Each accepted element SHALL shift a 1 into a PIPE_LAT-deep enable pipe; acc_en=1 exactly PIPE_LAT cycles after its handshake cycle.
REQ-022 A parallel last-flag pipe SHALL drive acc_vbit=1 only in the acc_en cycle of element len_q; acc_vbit=0 in all other cycles.
REQ-023 Gaps in in_valid SHALL propagate as acc_en=0 cycles; the pipe SHALL never drop or duplicate an element.
REQ-024 DRAIN: lasts exactly PIPE_LAT cycles, then go to DONE; acc_en for the last element occurs in the final DRAIN cycle.
REQ-025 DONE: res_valid=1, held until res_ready=1, then go to IDLE the following cycle; acc_en=0 and acc_clean=0 throughout.
REQ-026 start outside IDLE SHALL be ignored; cfg_len changes after capture SHALL have no effect.
REQ-027 cnt SHALL not wrap: the maximum legal cfg_len is 2^CNT_W-1, and in_ready=0 once cnt reaches len_q.
REQ-028 abort=1 in any non-IDLE state -> next cycle: IDLE, enable and last pipes cleared, acc_en=0, acc_clean=1 for exactly 1 cycle, res_valid=0.
REQ-029 abort and start in the same cycle in IDLE -> abort wins; start is dropped.
REQ-030 abort in IDLE SHALL only produce the 1-cycle acc_clean pulse.
REQ-031 busy=1 in CLEAR, ACC, DRAIN and DONE; busy=0 in IDLE.

Reset
REQ-032 rst=1 at a clock edge -> IDLE, cnt=0, len_q=0, pipes cleared.
REQ-033 Reset values: in_ready=0, acc_clean=0, acc_en=0, acc_vbit=0, res_valid=0, busy=0.
REQ-034 rst SHALL have priority over abort and start, including when asserted mid-job.

Verification
REQ-035 Basic job: PIPE_LAT=2, cfg_len=4, start at cycle 0, in_valid held 1 -> acc_clean cycle 1; handshakes cycles 2-5; acc_en cycles 4-7; acc_vbit cycle 7 only; res_valid from cycle 8.
REQ-036 Bubbles: cfg_len=3, in_valid pattern 1,0,1,1 from cycle 2 -> acc_en pattern 1,0,1,1 from cycle 4; acc_vbit on the 4th acc_en slot; exactly 3 acc_en pulses.
REQ-037 Zero length: cfg_len=0 -> acc_clean 1 cycle, then res_valid; zero acc_en pulses.
REQ-038 Back-pressure on result: res_ready held 0 for 5 cycles -> res_valid stays 1 and FSM stays in DONE; res_ready=1 -> IDLE next cycle; a start while in DONE is ignored.
REQ-039 Abort mid-ACC after 2 of 6 elements -> next cycle: IDLE, 1-cycle acc_clean, no further acc_en, acc_vbit never asserted, res_valid never asserted.
REQ-040 Max length: cfg_len=31 (CNT_W=5) -> exactly 31 handshakes and 31 acc_en pulses, no counter wrap; rst mid-DRAIN -> all outputs 0 next cycle.
